// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state, grant and default-width definitions for the SRAM controller
package sram_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_WR_TURN = 2'd2,
    ST_RD      = 2'd3
  } state_t;

  // Grant vector: bit0 = write port, bit1 = read port
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_WR   = 2'b01;
  localparam logic [1:0] GRANT_RD   = 2'b10;

  // Encoding of the most recently granted port
  localparam logic LAST_WR = 1'b0;
  localparam logic LAST_RD = 1'b1;

endpackage

// File: rtl/sram_rr_arb.sv
// rtl/sram_rr_arb.sv - two-way alternating arbiter between write and read ports
module sram_rr_arb
  import sram_pkg::*;
(
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last_grant
);

  logic last_grant_d;
  logic last_grant_q;

  // Lone requester wins; on contention the port that did not win last time goes next
  always_comb begin
    grant        = GRANT_NONE;
    last_grant_d = last_grant_q;
    if (advance) begin
      if (req == 2'b11) begin
        grant = (last_grant_q == LAST_RD) ? GRANT_WR : GRANT_RD;
      end else begin
        grant = req;
      end
      if (grant == GRANT_WR) begin
        last_grant_d = LAST_WR;
      end else if (grant == GRANT_RD) begin
        last_grant_d = LAST_RD;
      end
    end
  end

  // Remember the winner; reset to READ so the first contended grant goes to write
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      last_grant_q <= LAST_RD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/sram_arb_ctrl.sv
// rtl/sram_arb_ctrl.sv - async SRAM controller with arbitrated write/read ports and programmable timing
module sram_arb_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BE_W      = DATA_W / 8,
  parameter int WR_CYCLES = 1,
  parameter int RD_CYCLES = 2
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iWR_REQ,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  input  logic [BE_W-1:0]   iWR_BE,
  output logic              oWR_ACK,
  input  logic              iRD_REQ,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  output logic              oRD_ACK,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic              oRD_VALID,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_CE_N,
  output logic [BE_W-1:0]   oSRAM_BE_N
);

  localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);
  localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_n_q, be_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              ce_n_q, ce_n_d;
  logic              drive_en_q, drive_en_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [1:0]        grant;
  logic              unused_last_grant;

  sram_rr_arb u_arb (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .req        ({iRD_REQ, iWR_REQ}),
    .advance    (state_q == ST_IDLE),
    .grant      (grant),
    .last_grant (unused_last_grant)
  );

  // Next-state and registered-strobe computation for one SRAM access at a time
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_n_d     = be_n_q;
    we_n_d     = we_n_q;
    oe_n_d     = oe_n_q;
    ce_n_d     = ce_n_q;
    drive_en_d = drive_en_q;
    rd_data_d  = rd_data_q;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant == GRANT_WR) begin
          wr_ack_d   = 1'b1;
          addr_d     = iWR_ADDR;
          wdata_d    = iWR_DATA;
          be_n_d     = ~iWR_BE;
          ce_n_d     = 1'b0;
          we_n_d     = 1'b0;
          drive_en_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_WR;
        end else if (grant == GRANT_RD) begin
          rd_ack_d = 1'b1;
          addr_d   = iRD_ADDR;
          be_n_d   = '0;
          ce_n_d   = 1'b0;
          oe_n_d   = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RD;
        end
      end
      ST_WR: begin
        if (cnt_q == WR_LAST) begin
          we_n_d  = 1'b1;
          state_d = ST_WR_TURN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // Data held on DQ for one cycle past the WE_N rising edge
      ST_WR_TURN: begin
        drive_en_d = 1'b0;
        ce_n_d     = 1'b1;
        be_n_d     = '1;
        state_d    = ST_IDLE;
      end
      ST_RD: begin
        if (cnt_q == RD_LAST) begin
          rd_data_d  = SRAM_DQ;
          rd_valid_d = 1'b1;
          oe_n_d     = 1'b1;
          ce_n_d     = 1'b1;
          be_n_d     = '1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset parks every strobe high and releases DQ at once
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_n_q     <= '1;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      ce_n_q     <= 1'b1;
      drive_en_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_n_q     <= be_n_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      ce_n_q     <= ce_n_d;
      drive_en_q <= drive_en_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign SRAM_DQ    = drive_en_q ? wdata_q : 'z;
  assign oSRAM_ADDR = addr_q;
  assign oSRAM_WE_N = we_n_q;
  assign oSRAM_OE_N = oe_n_q;
  assign oSRAM_CE_N = ce_n_q;
  assign oSRAM_BE_N = be_n_q;
  assign oWR_ACK    = wr_ack_q;
  assign oRD_ACK    = rd_ack_q;
  assign oRD_DATA   = rd_data_q;
  assign oRD_VALID  = rd_valid_q;

endmodule
